// File: rtl/game_pkg.sv
// Shared state encoding and default widths for the round-control game logic.
package game_pkg;

  localparam int COUNT_W = 5;
  localparam int SCORE_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    WIN,
    LOSE
  } game_state_e;

endpackage

// File: rtl/rise_edge_detect.sv
// Single-cycle pulse on each rising edge of an already-synchronised level input.
module rise_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

  assign pulse = d & ~q;

endmodule

// File: rtl/game_controller.sv
// Round-control FSM driving the 4 Hz down-counter: arm, play, judge hits, timeout, score.
// Optional best-score register enabled by defining GAME_CONTROLLER_BEST_EN.
module game_controller
  import game_pkg::*;
#(
  parameter int CountWidth = COUNT_W,
  parameter int ScoreWidth = SCORE_W
) (
  input  logic                  clk_4_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  hit_i,
  input  logic [CountWidth-1:0] target_i,
  input  logic [CountWidth-1:0] count_i,
  output logic                  ctr_en_o,
  output logic                  ctr_rst_no,
  output logic                  win_o,
  output logic                  lose_o,
  output logic [ScoreWidth-1:0] score_o,
  output logic [ScoreWidth-1:0] best_o
);

  game_state_e           state, state_next;
  logic [CountWidth-1:0] target_q, target_next;
  logic [ScoreWidth-1:0] score, score_next;
  logic                  start_e, hit_e;

  function automatic logic [ScoreWidth-1:0] sat_inc(input logic [ScoreWidth-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  rise_edge_detect u_start_edge (
    .clk   (clk_4_i),
    .rst   (rst_i),
    .d     (start_i),
    .pulse (start_e)
  );

  rise_edge_detect u_hit_edge (
    .clk   (clk_4_i),
    .rst   (rst_i),
    .d     (hit_i),
    .pulse (hit_e)
  );

  always_ff @(posedge clk_4_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      target_q <= '0;
      score    <= '0;
    end else begin
      state    <= state_next;
      target_q <= target_next;
      score    <= score_next;
    end
  end

  // Counter is enabled only while counting is still possible, so it never wraps 0 -> all-ones.
  always_comb begin
    state_next  = state;
    target_next = target_q;
    score_next  = score;
    ctr_en_o    = 1'b0;
    ctr_rst_no  = 1'b0;
    win_o       = 1'b0;
    lose_o      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_e) state_next = ARM;
      end
      ARM: begin
        if (!start_i) begin
          state_next  = RUN;
          target_next = target_i;
        end
      end
      RUN: begin
        ctr_rst_no = 1'b1;
        ctr_en_o   = (count_i != '0);
        if (hit_e) begin
          if (count_i == target_q) begin
            state_next = WIN;
            score_next = sat_inc(score);
          end else begin
            state_next = LOSE;
          end
        end else if (count_i == '0) begin
          state_next = LOSE;
        end
      end
      WIN: begin
        ctr_rst_no = 1'b1;
        win_o      = 1'b1;
        if (start_e) state_next = ARM;
      end
      LOSE: begin
        ctr_rst_no = 1'b1;
        lose_o     = 1'b1;
        if (start_e) begin
          state_next = ARM;
          score_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign score_o = score;

`ifdef GAME_CONTROLLER_BEST_EN
  logic [ScoreWidth-1:0] best;

  // Tracks the incoming score so a new record shows up on the same edge as the win.
  always_ff @(posedge clk_4_i or posedge rst_i) begin
    if (rst_i)                   best <= '0;
    else if (score_next > best)  best <= score_next;
  end

  assign best_o = best;
`else
  assign best_o = '0;
`endif

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller paired with a down-counter; a cycle model feeds a scoreboard queue.
module tb_game_controller;
  import game_pkg::*;

  typedef struct packed {
    logic       win;
    logic       lose;
    logic       en;
    logic       rstn;
    logic [3:0] score;
    logic [3:0] best;
    logic [4:0] count;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic [4:0] target = 5'd0;
  logic [4:0] count = 5'd0;
  logic       ctr_en, ctr_rst_n, win, lose;
  logic [3:0] score, best;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t sb[$];

  game_state_e m_state = IDLE;
  logic [4:0]  m_count = 5'd0;
  logic [4:0]  m_target = 5'd0;
  logic [3:0]  m_score = 4'd0;
  logic [3:0]  m_best = 4'd0;
  logic        m_sq = 1'b0;
  logic        m_hq = 1'b0;

  game_controller dut (
    .clk_4_i    (clk),
    .rst_i      (rst),
    .start_i    (start),
    .hit_i      (hit),
    .target_i   (target),
    .count_i    (count),
    .ctr_en_o   (ctr_en),
    .ctr_rst_no (ctr_rst_n),
    .win_o      (win),
    .lose_o     (lose),
    .score_o    (score),
    .best_o     (best)
  );

  always #5 clk = ~clk;

  // Down-counter: synchronous active-low reload to all-ones, decrement when enabled.
  always_ff @(posedge clk) begin
    if (!ctr_rst_n)  count <= 5'h1f;
    else if (ctr_en) count <= count - 5'd1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = IDLE;
    m_target = 5'd0;
    m_score = 4'd0;
    m_best = 4'd0;
    m_sq = 1'b0;
    m_hq = 1'b0;
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then compare at the next negedge.
  task automatic step(input logic s, input logic h);
    exp_t        e, g;
    logic        se, he, en_m, rstn_m;
    logic [4:0]  nc;
    game_state_e ns;
    start = s;
    hit = h;
    rstn_m = (m_state == RUN) || (m_state == WIN) || (m_state == LOSE);
    en_m = (m_state == RUN) && (m_count != 5'd0);
    nc = !rstn_m ? 5'h1f : (en_m ? m_count - 5'd1 : m_count);
    ns = m_state;
    if (rst) begin
      model_reset();
      ns = IDLE;
    end else begin
      se = s & ~m_sq;
      he = h & ~m_hq;
      case (m_state)
        IDLE: if (se) ns = ARM;
        ARM:  if (!s) begin ns = RUN; m_target = target; end
        RUN: begin
          if (he && m_count == m_target) begin
            ns = WIN;
            if (m_score != 4'hf) m_score = m_score + 4'd1;
          end else if (he || m_count == 5'd0) begin
            ns = LOSE;
          end
        end
        WIN:  if (se) ns = ARM;
        LOSE: if (se) begin ns = ARM; m_score = 4'd0; end
        default: ns = IDLE;
      endcase
`ifdef GAME_CONTROLLER_BEST_EN
      if (m_score > m_best) m_best = m_score;
`endif
      m_sq = s;
      m_hq = h;
    end
    m_state = ns;
    m_count = nc;
    e.win   = (m_state == WIN);
    e.lose  = (m_state == LOSE);
    e.en    = (m_state == RUN) && (m_count != 5'd0);
    e.rstn  = (m_state == RUN) || (m_state == WIN) || (m_state == LOSE);
    e.score = m_score;
    e.best  = m_best;
    e.count = m_count;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    g = sb.pop_front();
    chk("win", win, g.win);
    chk("lose", lose, g.lose);
    chk("ctr_en", ctr_en, g.en);
    chk("ctr_rst_n", ctr_rst_n, g.rstn);
    chk("score", score, g.score);
    chk("best", best, g.best);
    chk("count", count, g.count);
  endtask

  // One round: start press/release, then hit when count equals hit_at (hit_at < 0: never hit).
  task automatic play_round(input logic [4:0] tgt, input int hit_at);
    int cyc;
    target = tgt;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    target = tgt ^ 5'h0a;
    cyc = 0;
    while (m_state == RUN && cyc < 64) begin
      if (hit_at >= 0 && int'(m_count) == hit_at) step(1'b0, 1'b1);
      else                                        step(1'b0, 1'b0);
      cyc++;
    end
    if (m_state == RUN) chk("round_timeout", 1, 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    #1;
    chk("rst_ctr_rst_n", ctr_rst_n, 0);
    chk("rst_ctr_en", ctr_en, 0);
    chk("rst_win", win, 0);
    chk("rst_lose", lose, 0);
    chk("rst_score", score, 0);
    chk("rst_best", best, 0);
    @(negedge clk);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("rst_count_reload", count, 31);
    rst = 1'b0;
    step(1'b0, 1'b0);

    play_round(5'd20, 20);
    chk("win_hit20", win, 1);
    chk("win_score1", score, 1);

    play_round(5'd20, 25);
    chk("lose_miss", lose, 1);
    step(1'b1, 1'b0);
    chk("lose_restart_score", score, 0);

    play_round(5'd5, -1);
    chk("timeout_lose", lose, 1);
    chk("timeout_nowrap", count, 0);

    play_round(5'd0, 0);
    chk("win_at_zero", win, 1);
    chk("win_at_zero_score", score, 1);

    // Asynchronous reset in the middle of a running round.
    target = 5'd10;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_ctr_rst_n", ctr_rst_n, 0);
    chk("async_ctr_en", ctr_en, 0);
    chk("async_score", score, 0);
    model_reset();
    @(negedge clk);
    step(1'b0, 1'b0);
    chk("async_count_reload", count, 31);
    rst = 1'b0;
    step(1'b0, 1'b0);

    for (int i = 0; i < 16; i++) play_round(5'd0, 0);
    chk("score_saturate", score, 15);

    rst = 1'b1;
    model_reset();
    step(1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) play_round(5'd0, 0);
    play_round(5'd20, 25);
    play_round(5'd0, 0);
    chk("best_seq_score", score, 1);
`ifdef GAME_CONTROLLER_BEST_EN
    chk("best_seq_best", best, 3);
`else
    chk("best_seq_best", best, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
